// File: rtl/ps2_device_emulator.sv
// ps2_device_emulator: PS/2 keyboard-side emulator that serialises FIFO'd scan codes as make/break frames
module ps2_device_emulator #(
  parameter int CLK_HALF   = 4,
  parameter int GAP_CYCLES = 16,
  parameter int DEPTH      = 8,
  parameter int BREAK_EN   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [7:0]               s_code,
  input  logic                     s_ext,
  input  logic                     s_perr,
  output logic                     ps2_clk,
  output logic                     ps2_data,
  output logic                     busy,
  output logic                     byte_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HIGH, S_LOW, S_GAP} state_t;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  state_t        r_state;
  logic [9:0]    r_ent;
  logic [2:0]    r_idx;
  logic [3:0]    r_bit;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop, w_par;
  logic [7:0]    w_byte;
  logic [10:0]   w_frame;
  logic [2:0]    w_last_idx;
  assign s_ready    = r_count < (AW+1)'(DEPTH);
  assign w_push     = s_valid && s_ready;
  assign w_pop      = r_state == S_LOAD;
  assign fifo_count = r_count;
  assign busy       = r_state != S_IDLE;
  // Entry byte order: ext -> E0,code,E0,F0,code ; plain -> code,F0,code (trimmed when break is off)
  assign w_byte     = r_ent[8] ? ((r_idx == 3'd1 || r_idx == 3'd4) ? r_ent[7:0] : (r_idx == 3'd3 ? 8'hF0 : 8'hE0))
                               : (r_idx == 3'd1 ? 8'hF0 : r_ent[7:0]);
  assign w_par      = ~^w_byte ^ r_ent[9];
  assign w_frame    = {1'b1, w_par, w_byte, 1'b0};
  assign w_last_idx = r_ent[8] ? ((BREAK_EN != 0) ? 3'd4 : 3'd1) : ((BREAK_EN != 0) ? 3'd2 : 3'd0);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {s_perr, s_ext, s_code};
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_count <= (w_push && !w_pop) ? r_count + (AW+1)'(1) :
                 (!w_push && w_pop) ? r_count - (AW+1)'(1) : r_count;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      ps2_clk   <= 1'b1;
      ps2_data  <= 1'b1;
      byte_done <= 1'b0;
      r_ent     <= '0;
      r_idx     <= '0;
      r_bit     <= '0;
      r_cnt     <= '0;
    end else begin
      byte_done <= 1'b0;
      case (r_state)
        S_IDLE: if (r_count != '0) r_state <= S_LOAD;
        S_LOAD: begin
          r_ent    <= r_mem[r_rp];
          r_idx    <= '0;
          r_bit    <= '0;
          r_cnt    <= '0;
          ps2_data <= 1'b0;
          r_state  <= S_HIGH;
        end
        S_HIGH: begin
          if (r_cnt == CW'(CLK_HALF - 1)) begin
            r_cnt   <= '0;
            ps2_clk <= 1'b0;
            r_state <= S_LOW;
          end else r_cnt <= r_cnt + CW'(1);
        end
        S_LOW: begin
          if (r_cnt == CW'(CLK_HALF - 1)) begin
            r_cnt   <= '0;
            ps2_clk <= 1'b1;
            if (r_bit == 4'd10) begin
              byte_done <= 1'b1;
              ps2_data  <= 1'b1;
              r_state   <= S_GAP;
            end else begin
              r_bit    <= r_bit + 4'd1;
              ps2_data <= w_frame[r_bit + 4'd1];
              r_state  <= S_HIGH;
            end
          end else r_cnt <= r_cnt + CW'(1);
        end
        S_GAP: begin
          if (r_cnt == CW'(GAP_CYCLES - 1)) begin
            r_cnt <= '0;
            if (r_idx == w_last_idx) r_state <= S_IDLE;
            else begin
              r_idx    <= r_idx + 3'd1;
              r_bit    <= '0;
              ps2_data <= 1'b0;
              r_state  <= S_HIGH;
            end
          end else r_cnt <= r_cnt + CW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_device_emulator.sv
// tb_ps2_device_emulator: directed bench with a PS/2 receiver model decoding the emitted frames
module tb_ps2_device_emulator;
  logic       clk = 0, reset = 1, s_valid = 0, s_ext = 0, s_perr = 0;
  logic [7:0] s_code = 0;
  logic       s_ready, ps2_clk, ps2_data, busy, byte_done;
  logic [3:0] fifo_count;
  int         n_chk = 0, n_pass = 0, bd_cnt = 0, max_cnt = 0;
  bit         saw_full = 0;
  logic [10:0] rx_sh = 0;
  logic [3:0] rx_n = 0;
  logic       prev = 1;
  logic [7:0] rx_q[$];
  logic       rx_pe_q[$];
  logic [10:0] rx_f_q[$];

  ps2_device_emulator #(.CLK_HALF(4), .GAP_CYCLES(16), .DEPTH(8), .BREAK_EN(1)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_code(s_code),
    .s_ext(s_ext), .s_perr(s_perr), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy),
    .byte_done(byte_done), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  // Host-side receiver: samples data on ps2_clk falling edges, records byte, parity error and raw frame
  always @(negedge clk) begin
    if (reset) begin
      rx_n = 0;
      prev = 1;
    end else begin
      if (prev && !ps2_clk) begin
        rx_sh[rx_n] = ps2_data;
        rx_n++;
        if (rx_n == 4'd11) begin
          rx_q.push_back(rx_sh[8:1]);
          rx_pe_q.push_back(~^rx_sh[9:1]);
          rx_f_q.push_back(rx_sh);
          rx_n = 0;
        end
      end
      prev = ps2_clk;
      if (byte_done) bd_cnt++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (!s_ready) saw_full = 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c, input logic e, input logic p);
    int  g = 0;
    logic ok;
    s_code = c; s_ext = e; s_perr = p; s_valid = 1;
    do begin
      ok = s_ready;
      tick();
      g++;
    end while (!ok && g < 5000);
    s_valid = 0;
    if (!ok) check("push accepted", 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while ((busy || fifo_count != 0) && g < 20000) begin
      tick();
      g++;
    end
    check({tag, " idle"}, !busy && fifo_count == 0, 1);
  endtask

  task automatic take(input string tag, input logic [7:0] b, input logic pe);
    logic [10:0] fr;
    if (rx_q.size() == 0) check({tag, " present"}, 0, 1);
    else begin
      check(tag, rx_q.pop_front(), b);
      check({tag, " perr"}, rx_pe_q.pop_front(), pe);
      fr = rx_f_q.pop_front();
      check({tag, " framing"}, {fr[10], fr[0]}, 2'b10);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) tick();
    check("rst ps2_clk", ps2_clk, 1);
    check("rst ps2_data", ps2_data, 1);
    check("rst s_ready", s_ready, 1);
    check("rst busy", busy, 0);
    check("rst byte_done", byte_done, 0);
    check("rst fifo_count", fifo_count, 0);
    reset = 0;
    tick();

    bd_cnt = 0;
    push(8'h1C, 0, 0);
    check("t1 count after push", fifo_count, 1);
    check("t1 idle after push", busy, 0);
    tick();
    check("t1 load busy", busy, 1);
    check("t1 load data high", ps2_data, 1);
    tick();
    check("t1 start bit", ps2_data, 0);
    check("t1 start clk high", ps2_clk, 1);
    check("t1 popped", fifo_count, 0);
    n = 0;
    while (ps2_clk && n < 50) begin tick(); n++; end
    check("t6 start to fall", n, 4);
    n = 0;
    while (!byte_done && n < 2000) begin tick(); n++; end
    check("t1 byte_done seen", byte_done, 1);
    n = 0;
    while (ps2_data && ps2_clk && n < 100) begin n++; tick(); end
    check("t6 gap cycles", n, 16);
    wait_idle("t1");
    check("t1 byte_done pulses", bd_cnt, 3);
    check("t1 frame bits", rx_f_q.size() > 0 ? rx_f_q[0] : 11'h7FF, 11'h438);
    take("t1 b0", 8'h1C, 0);
    take("t1 b1", 8'hF0, 0);
    take("t1 b2", 8'h1C, 0);

    push(8'h75, 1, 0);
    wait_idle("t2");
    take("t2 b0", 8'hE0, 0);
    take("t2 b1", 8'h75, 0);
    take("t2 b2", 8'hE0, 0);
    take("t2 b3", 8'hF0, 0);
    take("t2 b4", 8'h75, 0);
    check("t2 no extra", rx_q.size(), 0);

    push(8'h00, 0, 1);
    wait_idle("t3");
    check("t3 frame bits", rx_f_q.size() > 0 ? rx_f_q[0] : 11'h7FF, 11'h400);
    take("t3 b0", 8'h00, 1);
    take("t3 b1", 8'hF0, 1);
    take("t3 b2", 8'h00, 1);

    max_cnt = 0;
    saw_full = 0;
    for (int i = 0; i < 10; i++) push(8'(16 + i), 0, 0);
    check("t4 s_ready dropped", saw_full, 1);
    check("t4 max count", max_cnt, 8);
    wait_idle("t4");
    for (int i = 0; i < 10; i++) begin
      take("t4 make", 8'(16 + i), 0);
      take("t4 f0", 8'hF0, 0);
      take("t4 break", 8'(16 + i), 0);
    end

    push(8'h0F, 0, 0);
    push(8'h33, 0, 0);
    n = 0;
    while (!(rx_n == 4'd5 && ps2_clk) && n < 2000) begin tick(); n++; end
    check("t5 in bit4", rx_n, 5);
    check("t5 bit4 low", ps2_data, 0);
    check("t5 queued", fifo_count, 1);
    reset = 1;
    tick();
    check("t5 ps2_clk", ps2_clk, 1);
    check("t5 ps2_data", ps2_data, 1);
    check("t5 fifo_count", fifo_count, 0);
    check("t5 busy", busy, 0);
    reset = 0;
    repeat (300) tick();
    check("t5 stays idle", busy, 0);
    check("t5 no bytes", rx_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
